lfsr_period_checker: RTL
========================

// Module: lfsr_period_checker
// PURPOSE
//  Downstream monitor for the 12-bit LFSR top. Consumes lfsr_out/max_tick each CCLK and measures
//  the cycle count between consecutive max_tick pulses against the expected maximal-length period.
//  Also flags lock-up (forbidden value or a frozen register) and a missing tick (timeout).
//  Drives sticky pass/fail status for board LEDs and for the top-level self-check bench.
// PARAMETERS
//  WIDTH       12       LFSR register width
//  EXP_PERIOD  4095     expected cycles between max_tick pulses (2^WIDTH-1)
//  TIMEOUT     8190     count at which a missing tick is declared (must be > EXP_PERIOD)
//  LOCKUP_VAL  12'hFFF  forbidden lock-up value (all-ones for XNOR feedback)
// PORTS
//  CCLK          in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-low reset
//  en            in   1        1 = run the checker; 0 = return to IDLE
//  clr           in   1        synchronous clear of sticky flags and pass_cnt
//  lfsr_in       in   WIDTH    LFSR state (from lfsr_out)
//  max_tick_in   in   1        one-cycle period marker (from max_tick)
//  period_valid  out  1        one-cycle pulse: period_out updated
//  period_out    out  WIDTH+1  last measured period, in cycles
//  synced        out  1        high in MEASURE
//  err_period    out  1        sticky: measured period != EXP_PERIOD
//  err_stuck     out  1        sticky: lock-up detected
//  err_timeout   out  1        sticky: no tick within TIMEOUT cycles
//  pass_cnt      out  8        saturating count of correct periods (stops at 255)
// BEHAVIOUR
//  - reset low: state=IDLE; cnt, period_out, prev=0; all outputs 0. Takes effect with no clock.
//  - FSM IDLE -> SYNC when en=1. SYNC -> MEASURE on max_tick_in (cnt<=0).
//    MEASURE on max_tick_in: period_out<=cnt+1, period_valid=1 next cycle (latency 1), cnt<=0,
//    stays in MEASURE. en=0 in any state -> IDLE next cycle (cnt cleared, sticky flags kept).
//  - cnt: WIDTH+1 bits, increments every cycle in SYNC/MEASURE without a tick. If cnt reaches
//    TIMEOUT-1: err_timeout<=1, cnt<=0, state<=SYNC (re-arm). Never wraps.
//  - Compare at tick in MEASURE: cnt+1 == EXP_PERIOD -> pass_cnt++ (saturate at 8'hFF);
//    otherwise err_period<=1.
//  - Stuck check (SYNC and MEASURE; not the first cycle after leaving IDLE, where prev is
//    invalid): lfsr_in==LOCKUP_VAL, or lfsr_in==prev (prev = lfsr_in registered each cycle)
//    -> err_stuck<=1.
//  - clr: clears err_* and pass_cnt; FSM and cnt unaffected. If a set event and clr coincide,
//    the set wins: the flag is 1 next cycle.
//  - max_tick_in on the first SYNC cycle is accepted. Ticks in IDLE are ignored.
//  - Reset asserted mid-measurement aborts immediately; no period_valid is produced.
//  - period_valid is never asserted for the SYNC->MEASURE tick.
// STRUCTURE
//  - Shared package lfsr_pkg: LFSR_WIDTH=12, LFSR_PERIOD=4095, LFSR_LOCKUP=12'hFFF, and the
//    2-bit state encoding (IDLE=0, SYNC=1, MEASURE=2). Also used by the LFSR top.
//  - One sub-module, sat_counter (8-bit, inc/clr, saturating), for pass_cnt.
//  - Remainder is a single FSM plus the cnt/prev/flag registers.
// TESTING
//  1. Live LFSR top, reset low 2 cycles, en=1: the first period_valid shows period_out=4095;
//     after 3 periods pass_cnt=2 (the first tick only syncs) and all err_*=0.
//  2. Forced ticks 100 cycles apart, EXP_PERIOD=4095: period_valid with period_out=100;
//     err_period=1 and stays 1 until clr.
//  3. Hold lfsr_in=12'h5A5 for 2 cycles: err_stuck=1 next cycle. Drive lfsr_in=12'hFFF:
//     err_stuck=1.
//  4. Stop max_tick_in in MEASURE: err_timeout=1 exactly 8190 cycles after the last tick;
//     state=SYNC; the next tick re-syncs without a period_valid.
//  5. Pulse clr in the same cycle as a mismatching tick: err_period=1 (set wins). A clr alone
//     clears err_period and pass_cnt to 0.
//  6. Assert reset mid-MEASURE with no clock edge: all outputs 0 immediately. After release,
//     en=0 holds the FSM in IDLE and ticks are ignored.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 12-bit LFSR top and its downstream period checker.
package lfsr_pkg;

    localparam int unsigned     LFSR_WIDTH  = 12;
    localparam int unsigned     LFSR_PERIOD = 4095;
    localparam logic [11:0]     LFSR_LOCKUP = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } lfsr_state_e;

endpackage

// File: rtl/lfsr_period_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a coincident increment wins over clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q, cnt_d, base;

    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base != '1)) begin
            cnt_d = base + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/lfsr_period_checker.sv
// Measures cycles between max_tick pulses of the LFSR and raises sticky period/lock-up/timeout flags.
module lfsr_period_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned     WIDTH      = LFSR_WIDTH,
    parameter int unsigned     EXP_PERIOD = LFSR_PERIOD,
    parameter int unsigned     TIMEOUT    = 8190,
    parameter logic [WIDTH-1:0] LOCKUP_VAL = LFSR_LOCKUP
) (
    input  logic             CCLK,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] lfsr_in,
    input  logic             max_tick_in,
    output logic             period_valid,
    output logic [WIDTH:0]   period_out,
    output logic             synced,
    output logic             err_period,
    output logic             err_stuck,
    output logic             err_timeout,
    output logic [7:0]       pass_cnt
);

    localparam int unsigned CW      = WIDTH + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] EXP_CNT = CW'(EXP_PERIOD);

    lfsr_state_e      state_q;
    logic [CW-1:0]    cnt_q, cnt_inc, period_q;
    logic             valid_q;
    logic [WIDTH-1:0] prev_q;
    logic             prev_ok_q;
    logic             err_period_q, err_period_d;
    logic             err_stuck_q, err_stuck_d;
    logic             err_timeout_q, err_timeout_d;
    logic             active, tick_meas, period_ok, timeout_hit, stuck_hit;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        active      = en && (state_q != ST_IDLE);
        tick_meas   = active && max_tick_in && (state_q == ST_MEASURE);
        period_ok   = (cnt_inc == EXP_CNT);
        timeout_hit = active && !max_tick_in && (cnt_q == TO_LAST);
        // prev_q is meaningless on the first cycle after IDLE, hence prev_ok_q
        stuck_hit   = active && prev_ok_q &&
                      ((lfsr_in == LOCKUP_VAL) || (lfsr_in == prev_q));
        err_period_d  = (tick_meas && !period_ok) || (err_period_q && !clr);
        err_stuck_d   = stuck_hit || (err_stuck_q && !clr);
        err_timeout_d = timeout_hit || (err_timeout_q && !clr);
    end

    always_ff @(posedge CCLK or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!en) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SYNC;
                        cnt_q   <= '0;
                    end
                    ST_SYNC, ST_MEASURE: begin
                        if (max_tick_in) begin
                            if (state_q == ST_MEASURE) begin
                                period_q <= cnt_inc;
                                valid_q  <= 1'b1;
                            end
                            cnt_q   <= '0;
                            state_q <= ST_MEASURE;
                        end else if (cnt_q == TO_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_SYNC;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CCLK or negedge reset) begin
        if (!reset) begin
            prev_q        <= '0;
            prev_ok_q     <= 1'b0;
            err_period_q  <= 1'b0;
            err_stuck_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            prev_q        <= lfsr_in;
            prev_ok_q     <= active;
            err_period_q  <= err_period_d;
            err_stuck_q   <= err_stuck_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    sat_counter #(.W(8)) u_pass_cnt (
        .clk_i   (CCLK),
        .rst_ni  (reset),
        .inc_i   (tick_meas && period_ok),
        .clr_i   (clr),
        .count_o (pass_cnt)
    );

    assign period_valid = valid_q;
    assign period_out   = period_q;
    assign synced       = (state_q == ST_MEASURE);
    assign err_period   = err_period_q;
    assign err_stuck    = err_stuck_q;
    assign err_timeout  = err_timeout_q;

endmodule
